// File: rtl/enet_rst_pkg.sv
// Shared types and constants for the ENET PHY reset sequencer.
package enet_rst_pkg;

  localparam int unsigned CNT_W_DEFAULT = 24;
  localparam logic [1:0]  ENET_RST_ADDR = 2'd0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_LOW   = 3'd1,
    ST_HOLD     = 3'd2,
    ST_WR_HIGH  = 3'd3,
    ST_SETTLE   = 3'd4,
    ST_RD_CHK   = 3'd5,
    ST_DONE     = 3'd6,
    ST_ERROR    = 3'd7
  } state_e;

endpackage

// File: rtl/enet_rst_timer.sv
// Loadable down-counter for the HOLD/SETTLE intervals.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   load_i        load value_i this cycle
//   value_i       interval length in cycles (>= 1)
//   expire_o      registered; high during the last cycle of the interval (count == 1)
module enet_rst_timer
  import enet_rst_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] value_i,
  output logic             expire_o
);

  logic [CNT_W-1:0] cnt_q;
  logic             expire_q;

  // expire_q is precomputed so it is high exactly while cnt_q == 1
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      expire_q <= 1'b0;
    end else if (load_i) begin
      cnt_q    <= value_i;
      expire_q <= (value_i == CNT_W'(1));
    end else begin
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      expire_q <= (cnt_q == CNT_W'(2));
    end
  end

  assign expire_o = expire_q;

endmodule

// File: rtl/enet_reset_sequencer.sv
// Avalon-MM master that pulses the ENET PHY reset PIO bit (write 0, hold,
// write 1, settle, read back 1) with retry on readback mismatch.
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   start              launch request, honoured only in IDLE/DONE/ERROR
//   busy/done/error    run status (levels)
//   retry_cnt          retries consumed in current/last run
//   avm_*              Avalon-MM master to the PIO slave (read latency 0)
module enet_reset_sequencer
  import enet_rst_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 5000,
  parameter int unsigned SETTLE_CYCLES = 50000,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter int unsigned AUTO_START    = 1,
  parameter int unsigned CNT_W         = CNT_W_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [2:0] retry_cnt,
  output logic [1:0] avm_address,
  output logic       avm_chipselect,
  output logic       avm_write_n,
  output logic       avm_read_n,
  output logic       avm_writedata,
  input  logic       avm_readdata,
  input  logic       avm_waitrequest
);

  state_e           state_q;
  logic [2:0]       retry_cnt_q;
  logic             busy_q, done_q, error_q;
  logic             cs_q, write_n_q, read_n_q, wdata_q;

  logic             launch_c, wr_low_ack_c, wr_high_ack_c, retry_ok_c;
  logic             tmr_load_c, tmr_expire;
  logic [CNT_W-1:0] tmr_value_c;

  // IDLE is only reached from reset, so auto-start naturally fires once per reset
  assign launch_c = ((state_q == ST_IDLE) && ((AUTO_START != 0) || start)) ||
                    (((state_q == ST_DONE) || (state_q == ST_ERROR)) && start);

  assign wr_low_ack_c  = (state_q == ST_WR_LOW)  && !avm_waitrequest;
  assign wr_high_ack_c = (state_q == ST_WR_HIGH) && !avm_waitrequest;
  assign retry_ok_c    = (retry_cnt_q < 3'(MAX_RETRIES));

  // Timer loads on the cycle the write is accepted, i.e. on entry to HOLD/SETTLE
  assign tmr_load_c  = wr_low_ack_c || wr_high_ack_c;
  assign tmr_value_c = wr_low_ack_c ? CNT_W'(HOLD_CYCLES) : CNT_W'(SETTLE_CYCLES);

  enet_rst_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load_i   (tmr_load_c),
    .value_i  (tmr_value_c),
    .expire_o (tmr_expire)
  );

  // Sequencer FSM with registered status and bus strobes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      retry_cnt_q <= 3'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      cs_q        <= 1'b0;
      write_n_q   <= 1'b1;
      read_n_q    <= 1'b1;
      wdata_q     <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (launch_c) begin
            state_q     <= ST_WR_LOW;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            retry_cnt_q <= 3'd0;
            cs_q        <= 1'b1;
            write_n_q   <= 1'b0;
            wdata_q     <= 1'b0;
          end
        end
        ST_WR_LOW: begin
          if (!avm_waitrequest) begin
            state_q   <= ST_HOLD;
            cs_q      <= 1'b0;
            write_n_q <= 1'b1;
            wdata_q   <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (tmr_expire) begin
            state_q   <= ST_WR_HIGH;
            cs_q      <= 1'b1;
            write_n_q <= 1'b0;
            wdata_q   <= 1'b1;
          end
        end
        ST_WR_HIGH: begin
          if (!avm_waitrequest) begin
            state_q   <= ST_SETTLE;
            cs_q      <= 1'b0;
            write_n_q <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (tmr_expire) begin
            state_q  <= ST_RD_CHK;
            cs_q     <= 1'b1;
            read_n_q <= 1'b0;
          end
        end
        ST_RD_CHK: begin
          if (!avm_waitrequest) begin
            read_n_q <= 1'b1;
            if (avm_readdata) begin
              state_q <= ST_DONE;
              cs_q    <= 1'b0;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else if (retry_ok_c) begin
              // Retry goes straight into the next low write; chipselect stays up
              state_q     <= ST_WR_LOW;
              retry_cnt_q <= retry_cnt_q + 3'd1;
              write_n_q   <= 1'b0;
              wdata_q     <= 1'b0;
            end else begin
              state_q <= ST_ERROR;
              cs_q    <= 1'b0;
              error_q <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign retry_cnt      = retry_cnt_q;
  assign avm_address    = ENET_RST_ADDR;
  assign avm_chipselect = cs_q;
  assign avm_write_n    = write_n_q;
  assign avm_read_n     = read_n_q;
  assign avm_writedata  = wdata_q;

endmodule

// File: tb/tb_enet_reset_sequencer.sv
// Self-checking bench for enet_reset_sequencer with a 1-bit PIO slave model.
module tb_enet_reset_sequencer;

  localparam int H    = 4;
  localparam int S    = 6;
  localparam int MAXR = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, error;
  logic [2:0] retry_cnt;
  logic [1:0] avm_address;
  logic       avm_chipselect, avm_write_n, avm_read_n, avm_writedata;
  logic       avm_readdata = 1'b0;
  logic       avm_waitrequest = 1'b0;

  always #5 clk = ~clk;

  enet_reset_sequencer #(
    .HOLD_CYCLES(H), .SETTLE_CYCLES(S), .MAX_RETRIES(MAXR), .AUTO_START(1), .CNT_W(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .busy(busy), .done(done), .error(error), .retry_cnt(retry_cnt),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_write_n(avm_write_n), .avm_read_n(avm_read_n),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest)
  );

  typedef struct {
    bit         is_rd;
    logic       data;
    logic [1:0] addr;
    int         cyc;
    int         stall;
  } txn_t;

  typedef struct {
    int stall;
    int zeros;
    bit e_done;
    bit e_err;
    int e_retry;
    int e_ntxn;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   launch_cyc = 0;
  int   fixed_stall = 0;   // < 0 selects a random stall per access
  int   zeros_left = 0;    // reads forced to return 0 before the slave answers normally
  txn_t log_q[$];

  logic pio = 1'b1;
  int   acc_cyc = 0;
  int   stall_cur = 0;
  bit   in_acc = 1'b0;
  logic cap_wn, cap_rn, cap_wd;
  txn_t mon_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int pick_stall();
    return (fixed_stall >= 0) ? fixed_stall : int'($urandom_range(0, 3));
  endfunction

  always @(posedge clk) cyc++;

  // Slave model: decides waitrequest/readdata at negedge for the coming posedge
  always @(negedge clk) begin
    if (!reset_n) begin
      pio             = 1'b1;
      in_acc          = 1'b0;
      avm_waitrequest = 1'b0;
    end else if (avm_chipselect) begin
      if (!in_acc) begin
        in_acc    = 1'b1;
        acc_cyc   = 0;
        stall_cur = pick_stall();
        cap_wn    = avm_write_n;
        cap_rn    = avm_read_n;
        cap_wd    = avm_writedata;
      end else begin
        chk("strobe_steady", {29'd0, avm_write_n, avm_read_n, avm_writedata},
            {29'd0, cap_wn, cap_rn, cap_wd});
      end
      if (acc_cyc < stall_cur) begin
        avm_waitrequest = 1'b1;
        avm_readdata    = ~pio;
        acc_cyc++;
      end else begin
        avm_waitrequest = 1'b0;
        in_acc          = 1'b0;
        mon_t.is_rd     = !avm_read_n;
        mon_t.addr      = avm_address;
        mon_t.cyc       = cyc + 1;
        mon_t.stall     = stall_cur;
        if (!avm_read_n) begin
          if (zeros_left > 0) begin
            mon_t.data = 1'b0;
            zeros_left--;
          end else begin
            mon_t.data = pio;
          end
          avm_readdata = mon_t.data;
        end else begin
          mon_t.data = avm_writedata;
          pio        = avm_writedata;
        end
        log_q.push_back(mon_t);
      end
    end else begin
      in_acc          = 1'b0;
      avm_waitrequest = 1'($urandom_range(0, 1));
      avm_readdata    = 1'($urandom_range(0, 1));
    end
  end

  task automatic check_reset_vals(input string name);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_done"}, done, 0);
    chk({name, "_error"}, error, 0);
    chk({name, "_retry"}, retry_cnt, 0);
    chk({name, "_addr"}, avm_address, 0);
    chk({name, "_cs"}, avm_chipselect, 0);
    chk({name, "_write_n"}, avm_write_n, 1);
    chk({name, "_read_n"}, avm_read_n, 1);
    chk({name, "_wdata"}, avm_writedata, 1);
  endtask

  // Called at the first negedge after the launch edge
  task automatic check_launch(input string name);
    chk({name, "_launch_busy"}, busy, 1);
    chk({name, "_launch_done"}, done, 0);
    chk({name, "_launch_error"}, error, 0);
    chk({name, "_launch_retry"}, retry_cnt, 0);
  endtask

  task automatic wait_final(input string name);
    for (int k = 0; k < 3000; k++) begin
      if (!busy) break;
      @(negedge clk);
    end
    chk({name, "_timeout_busy"}, busy, 0);
  endtask

  // Reference: each attempt is W0, W1, R; gaps follow from the interval lengths and stalls
  task automatic check_run(input string name, input int zeros);
    int att;
    int n;
    int t;
    att = (zeros <= MAXR) ? zeros + 1 : MAXR + 1;
    n   = 3 * att;
    t   = launch_cyc;
    chk({name, "_ntxn"}, log_q.size(), n);
    for (int i = 0; i < n; i++) begin
      int   ph;
      int   st;
      logic ed;
      ph = i % 3;
      st = (i < log_q.size()) ? log_q[i].stall : 0;
      t += st + ((ph == 0) ? 1 : (ph == 1) ? H + 1 : S + 1);
      ed = (ph == 0) ? 1'b0 : (ph == 1) ? 1'b1 : ((i / 3) < zeros ? 1'b0 : 1'b1);
      if (i < log_q.size()) begin
        chk($sformatf("%s_t%0d_cyc", name, i), log_q[i].cyc, t);
        chk($sformatf("%s_t%0d_kind", name, i),
            {28'd0, log_q[i].is_rd, log_q[i].data, log_q[i].addr},
            {28'd0, (ph == 2), ed, 2'b00});
      end
    end
    chk({name, "_done"}, done, (zeros <= MAXR));
    chk({name, "_error"}, error, (zeros > MAXR));
    chk({name, "_retry"}, retry_cnt, (zeros < MAXR) ? zeros : MAXR);
    chk({name, "_excl"}, done & error, 0);
  endtask

  task automatic pulse_launch();
    @(negedge clk);
    start = 1'b1;
    launch_cyc = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_start(input string name, input int zeros);
    zeros_left = zeros;
    log_q.delete();
    pulse_launch();
    check_launch(name);
    wait_final(name);
    check_run(name, zeros);
  endtask

  task automatic wait_txns(input string name, input int n);
    for (int k = 0; k < 500; k++) begin
      if (log_q.size() >= n) break;
      @(negedge clk);
    end
    chk({name, "_reach"}, (log_q.size() >= n), 1);
  endtask

  // Release reset at a negedge; AUTO_START launches on the next posedge
  task automatic release_and_autorun(input string name);
    repeat (2) @(negedge clk);
    log_q.delete();
    zeros_left = 0;
    reset_n = 1'b1;
    launch_cyc = cyc + 1;
    @(negedge clk);
    check_launch(name);
    wait_final(name);
    check_run(name, 0);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{0, 0, 1'b1, 1'b0, 0, 3};
    vecs[1] = '{3, 0, 1'b1, 1'b0, 0, 3};
    vecs[2] = '{0, 2, 1'b1, 1'b0, 2, 9};
    vecs[3] = '{0, 4, 1'b0, 1'b1, 3, 12};
    vecs[4] = '{1, 1, 1'b1, 1'b0, 1, 6};
    vecs[5] = '{2, 3, 1'b1, 1'b0, 3, 12};
    vecs[6] = '{0, 7, 1'b0, 1'b1, 3, 12};

    // Reset values and the automatic first run
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    release_and_autorun("auto");
    if (log_q.size() >= 2) chk("pio_low_span", log_q[1].cyc - log_q[0].cyc, H + 1);
    chk("pio_final", pio, 1);

    // Table-driven runs launched by start from DONE/ERROR
    for (int i = 0; i < 7; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      fixed_stall = vecs[i].stall;
      run_start(nm, vecs[i].zeros);
      chk({nm, "_tbl_done"}, done, vecs[i].e_done);
      chk({nm, "_tbl_error"}, error, vecs[i].e_err);
      chk({nm, "_tbl_retry"}, retry_cnt, vecs[i].e_retry);
      chk({nm, "_tbl_ntxn"}, log_q.size(), vecs[i].e_ntxn);
    end

    // Randomized stalls and readback failures
    fixed_stall = -1;
    for (int i = 0; i < 12; i++) begin
      run_start($sformatf("rnd%0d", i), int'($urandom_range(0, 5)));
    end

    // start pulses during HOLD and SETTLE must be ignored
    fixed_stall = 0;
    zeros_left = 0;
    log_q.delete();
    pulse_launch();
    check_launch("ign");
    wait_txns("ign_w0", 1);
    @(negedge clk);
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_txns("ign_w1", 2);
    @(negedge clk);
    start = 1'b1;
    repeat (4) @(negedge clk);
    start = 1'b0;
    wait_final("ign");
    check_run("ign", 0);

    // Reset asserted mid-HOLD: outputs return to reset values before the next edge
    fixed_stall = 0;
    log_q.delete();
    pulse_launch();
    wait_txns("rh_w0", 1);
    repeat (2) @(negedge clk);
    chk("rh_busy_before", busy, 1);
    #3 reset_n = 1'b0;
    #1 check_reset_vals("rst_hold");
    release_and_autorun("rh_rerun");

    // Reset asserted during a stalled write: bus goes idle immediately
    fixed_stall = 20;
    log_q.delete();
    pulse_launch();
    chk("ra_cs_before", avm_chipselect, 1);
    @(negedge clk);
    #3 reset_n = 1'b0;
    #1 check_reset_vals("rst_access");
    fixed_stall = -1;
    release_and_autorun("ra_rerun");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
